issue_pair_serializer: RTL
==========================

# issue_pair_serializer

Downstream consumer of the two-picker issue queue. It accepts up to two entries per cycle on two ordered lanes, buffers them in a small circular FIFO, and drains them one per cycle to a single-wide execution port. Lane 1 carries the entry that is younger than lane 0's, and it is consumed only together with lane 0. This preserves the queue's in-order issue semantics across the width change.

## Interface
- DATA_W, 8, payload width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, occupancy width (derived).

- sys_clk  in  1  clock, all state updates on rising edge.
- sys_rst  in  1  reset; synchronous and active-high.
- in0_valid  in  1  lane 0 (older) entry present.
- in0_data  in  DATA_W  lane 0 payload.
- in0_ready  out  1  lane 0 can be accepted this cycle.
- in1_valid  in  1  lane 1 (younger) entry present.
- in1_data  in  DATA_W  lane 1 payload.
- in1_ready  out  1  lane 1 can be accepted this cycle.
- out_valid  out  1  head entry available.
- out_data  out  DATA_W  head payload; 0 when out_valid=0.
- out_ready  in  1  consumer takes head this cycle.
- count  out  CNT_W  current occupancy, registered.

## Operation
- State consists of:
  - mem[DEPTH], which is not reset.
  - rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, CNT_W bits.
- The ready outputs depend only on the registered count, so there is no combinational path from out_ready.
  - in0_ready = (count ≤ DEPTH-1).
  - in1_ready = (count ≤ DEPTH-2).
- acc0 = in0_valid & in0_ready.
- acc1 = in1_valid & in1_ready & acc0.
  - A lane-1 entry without a lane-0 entry is never accepted.
  - If in1_valid is high while acc0=0, the entry is dropped from this cycle's view, and the upstream must hold it.
- Writes:
  - On acc0, mem[wr_ptr] ← in0_data.
  - On acc1, mem[wr_ptr+1 mod DEPTH] ← in1_data.
  - wr_ptr advances by acc0+acc1.
- pop = out_valid & out_ready.
  - On pop, rd_ptr advances by 1.
- count_next = count + acc0 + acc1 − pop.
  - Full arithmetic is performed in CNT_W bits. By construction it never exceeds DEPTH and never goes below 0.
- out_valid = (count ≠ 0). When valid, out_data = mem[rd_ptr].
- Ordering: the output sequence equals the accepted sequence, where lane 0 precedes lane 1 within a cycle and earlier cycles precede later ones.
- Boundary behaviour:
  - Full (count=DEPTH): both readies are 0, even if pop=1 this cycle. Space freed by a pop becomes visible next cycle.
  - count=DEPTH-1: only lane 0 is accepted.
  - Empty (count=0): out_valid=0 and out_data=0. A push this cycle is not bypassed to the output.
  - Simultaneous push(es) and pop: both take effect; count changes by the net amount.
  - Pointer wrap: a pair write may straddle the index DEPTH-1 → 0.

## Timing
- Latency: an entry accepted at edge N is visible on out_valid/out_data after edge N; the earliest pop is in cycle N+1.
- Throughput: 2 entries/cycle in, 1 entry/cycle out.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, so out_valid=0, out_data=0, in0_ready=1 and in1_ready=1.
- Reset mid-operation:
  - Asserting sys_rst at an edge discards all contents, regardless of valid or ready inputs in that cycle.
  - No accept or pop is performed in a reset cycle.
  - Outputs show reset values in the following cycle.

## Test plan
- Reset: after sys_rst is held for 2 edges:
  - out_valid=0, out_data=0x00, count=0, in0_ready=1, in1_ready=1.
- Pair fill, no drain (out_ready=0):
  - Cycle 1: push (0x11,0x22) → count=2.
  - Cycle 2: push (0x33,0x44) → count=4, in0_ready=0, in1_ready=0.
  - Cycle 3: push 0x55 → rejected.
  - Then drain with out_ready=1 → output sequence 0x11,0x22,0x33,0x44, then out_valid=0.
- Partial space:
  - From count=3 (0xA1,0xA2,0xA3 pushed via lane 0), present both lanes (0xB1,0xB2) → only 0xB1 accepted, count=4.
  - Drain → 0xA1,0xA2,0xA3,0xB1.
- Lane-1-only:
  - in0_valid=0, in1_valid=1 (0xCC) at count=0 → nothing accepted, count stays 0, out_valid=0 next cycle.
- Simultaneous push/pop with wrap:
  - Setup: rd_ptr=wr_ptr=3 with count=0, reached by pushing and popping 3 entries singly.
  - Sequence:
    - push (0x01,0x02), which straddles index 3 → 0;
    - next cycle, push (0x03,0x04) with out_ready=1 → count goes 2→3;
    - then drain.
  - Expected output sequence: 0x01,0x02,0x03,0x04 with no gaps.
- Reset mid-operation:
  - At count=3, assert sys_rst for one cycle with in0_valid=1 and out_ready=1.
  - Next cycle: count=0, out_valid=0.
  - Then push 0x77 → output 0x77 only.

Source files
------------

// File: rtl/issue_pair_serializer_if.sv
// Handshake bundle between the two-lane issue picker, the serializer and the
// single-wide execution port. The serializer is the slave; the side that
// supplies entries and consumes the head is the master.
interface issue_pair_serializer_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
);
  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic              in0_ready;
  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic              in1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, count
  );

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/issue_pair_serializer.sv
// Two-lane to one-lane serializer behind the issue queue. Up to two ordered
// entries are written per cycle into a small circular FIFO and drained one
// per cycle. Lane 1 (younger) is only ever taken together with lane 0, so
// the drain order is exactly the issue order.
module issue_pair_serializer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  issue_pair_serializer_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LIM_ONE = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LIM_TWO = CNT_W'(DEPTH - 2);

  // Storage is data only; it is never cleared, occupancy decides validity.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_in0_ready;
  logic              w_in1_ready;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_wr0;
  logic              w_wr1;
  logic              w_out_valid;
  logic              w_pop;
  logic [PTR_W-1:0]  w_wr_ptr1;
  logic [PTR_W-1:0]  w_wr_ptr_next;
  logic [PTR_W-1:0]  w_rd_ptr_next;
  logic [CNT_W-1:0]  w_count_next;

  // Readies come from registered occupancy only: no path from out_ready,
  // so space freed by a pop is offered one cycle later.
  always_comb begin
    w_in0_ready = (r_count <= LIM_ONE);
    w_in1_ready = (r_count <= LIM_TWO);
  end

  // Accept and pop qualification; lane 1 needs lane 0 in the same cycle.
  always_comb begin
    w_acc0      = bus.in0_valid & w_in0_ready;
    w_acc1      = bus.in1_valid & w_in1_ready & w_acc0;
    w_out_valid = (r_count != '0);
    w_pop       = w_out_valid & bus.out_ready;
    w_wr0       = w_acc0 & ~sys_rst;
    w_wr1       = w_acc1 & ~sys_rst;
  end

  // Next pointers and occupancy; power-of-two depth makes the wrap free.
  always_comb begin
    w_wr_ptr1     = r_wr_ptr + PTR_W'(1);
    w_wr_ptr_next = r_wr_ptr + PTR_W'(w_acc0) + PTR_W'(w_acc1);
    w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);
    w_count_next  = r_count + CNT_W'(w_acc0) + CNT_W'(w_acc1) - CNT_W'(w_pop);
  end

  // Payload writes; a pair may straddle the last index back to 0.
  always_ff @(posedge sys_clk) begin
    if (w_wr0) r_mem[r_wr_ptr]  <= bus.in0_data;
    if (w_wr1) r_mem[w_wr_ptr1] <= bus.in1_data;
  end

  // Control state; reset discards contents and suppresses accept and pop.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_count  <= w_count_next;
    end
  end

  // Output drive; payload is forced to zero while empty, no push bypass.
  always_comb begin
    bus.in0_ready = w_in0_ready;
    bus.in1_ready = w_in1_ready;
    bus.out_valid = w_out_valid;
    bus.out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
    bus.count     = r_count;
  end
endmodule
